// File: rtl/lz77_match_sel_pkg.sv
// Shared types and sizes for the LZ77 match path.
// Used by the comparator stage, the selector and the encoder top.
package lz77_match_sel_pkg;

   localparam int WIN_DEFAULT = 9;
   localparam int LEN_W       = 3;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   function automatic logic [LEN_W-1:0] min_len(
      input logic [LEN_W-1:0] a,
      input logic [LEN_W-1:0] b
   );
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/lz77_match_sel.sv
// Longest-match selector: walks window offsets one per cycle and keeps the
// longest clipped match; the comparator sits outside and follows offset_idx.
module lz77_match_sel
   import lz77_match_sel_pkg::*;
#(
   parameter int WIN = WIN_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       win_cnt,
   input  logic [LEN_W-1:0] max_len,
   input  logic [LEN_W-1:0] len_in,
   output logic [3:0]       offset_idx,
   output logic             busy,
   output logic             done,
   output logic [3:0]       match_offset,
   output logic [LEN_W-1:0] match_len
);

   localparam logic [3:0] WIN_W = 4'(WIN);

   state_t           state_q, state_d;
   logic [3:0]       off_q, off_d;
   logic [3:0]       win_q, win_d;
   logic [LEN_W-1:0] max_q, max_d;
   logic [LEN_W-1:0] best_len_q, best_len_d;
   logic [3:0]       best_off_q, best_off_d;
   logic [3:0]       mo_q, mo_d;
   logic [LEN_W-1:0] ml_q, ml_d;
   logic [LEN_W-1:0] eff_len;
   logic [3:0]       win_sat;

   always_comb begin
      state_d    = state_q;
      off_d      = off_q;
      win_d      = win_q;
      max_d      = max_q;
      best_len_d = best_len_q;
      best_off_d = best_off_q;
      mo_d       = mo_q;
      ml_d       = ml_q;
      eff_len    = min_len(len_in, max_q);
      win_sat    = (win_cnt > WIN_W) ? WIN_W : win_cnt;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               win_d      = win_sat;
               max_d      = max_len;
               best_len_d = '0;
               best_off_d = '0;
               off_d      = '0;
               if (win_sat == 4'd0) begin
                  state_d = DONE;
                  mo_d    = '0;
                  ml_d    = '0;
               end else begin
                  state_d = SCAN;
               end
            end
         end
         SCAN: begin
            // strict compare keeps the lowest offset on ties
            if (eff_len > best_len_q) begin
               best_len_d = eff_len;
               best_off_d = off_q;
            end
            if (off_q == win_q - 4'd1 || eff_len == max_q) begin
               state_d = DONE;
               off_d   = '0;
               mo_d    = best_off_d;
               ml_d    = best_len_d;
            end else begin
               off_d = off_q + 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         off_q      <= '0;
         win_q      <= '0;
         max_q      <= '0;
         best_len_q <= '0;
         best_off_q <= '0;
         mo_q       <= '0;
         ml_q       <= '0;
      end else begin
         state_q    <= state_d;
         off_q      <= off_d;
         win_q      <= win_d;
         max_q      <= max_d;
         best_len_q <= best_len_d;
         best_off_q <= best_off_d;
         mo_q       <= mo_d;
         ml_q       <= ml_d;
      end
   end

   assign offset_idx   = off_q;
   assign busy         = (state_q == SCAN);
   assign done         = (state_q == DONE);
   assign match_offset = mo_q;
   assign match_len    = ml_q;

endmodule

// File: tb/tb_lz77_match_sel.sv
// Randomized and directed bench for lz77_match_sel against a
// longest-match reference model.
module tb_lz77_match_sel;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] win_cnt;
   logic [2:0] max_len;
   logic [2:0] len_in;
   logic [3:0] offset_idx;
   logic       busy;
   logic       done;
   logic [3:0] match_offset;
   logic [2:0] match_len;

   logic [2:0] len_tbl [16];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   // comparator stand-in: length for whatever offset is presented
   assign len_in = len_tbl[offset_idx];

   lz77_match_sel #(.WIN(9)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .win_cnt      (win_cnt),
      .max_len      (max_len),
      .len_in       (len_in),
      .offset_idx   (offset_idx),
      .busy         (busy),
      .done         (done),
      .match_offset (match_offset),
      .match_len    (match_len)
   );

   // longest clipped match over the window, first offset wins ties
   task automatic model(input int win, input int maxl,
                        output int n, output int eoff, output int elen);
      int lim;
      int e;
      lim  = (win > 9) ? 9 : win;
      n    = 0;
      eoff = 0;
      elen = 0;
      for (int i = 0; i < lim; i++) begin
         e = (int'(len_tbl[i]) < maxl) ? int'(len_tbl[i]) : maxl;
         n = i + 1;
         if (e > elen) begin
            elen = e;
            eoff = i;
         end
         if (e == maxl) break;
      end
   endtask

   task automatic run_search(input string name, input int win,
                             input int maxl, input bit spam);
      int n, eoff, elen;
      logic [5:0] exp_v;
      model(win, maxl, n, eoff, elen);
      @(posedge clk); #1;
      start   = 1'b1;
      win_cnt = 4'(win);
      max_len = 3'(maxl);
      @(posedge clk); #1;
      start   = 1'b0;
      win_cnt = 4'($urandom);
      max_len = 3'($urandom);
      for (int k = 1; k <= n + 1; k++) begin
         exp_v = {k <= n, k == n + 1, (k <= n) ? 4'(k - 1) : 4'd0};
         n_checks++;
         if ({busy, done, offset_idx} !== exp_v) begin
            $display("FAIL %s cycle %0d: busy/done/off got %b want %b",
                     name, k, {busy, done, offset_idx}, exp_v);
         end else begin
            n_pass++;
         end
         if (k == n + 1) begin
            n_checks++;
            if ({match_offset, match_len} !== {4'(eoff), 3'(elen)}) begin
               $display("FAIL %s result: off=%0d len=%0d want off=%0d len=%0d",
                        name, match_offset, match_len, eoff, elen);
            end else begin
               n_pass++;
            end
         end
         if (spam) begin
            start   = 1'b1;
            win_cnt = 4'($urandom);
            max_len = 3'($urandom);
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      n_checks++;
      if ({busy, done, offset_idx} !== 6'b0) begin
         $display("FAIL %s after done: busy/done/off got %b want 000000",
                  name, {busy, done, offset_idx});
      end else begin
         n_pass++;
      end
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      start   = 1'b1;
      win_cnt = 4'd9;
      max_len = 3'd7;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      start = 1'b0;
      n_checks++;
      if ({busy, done, offset_idx, match_offset, match_len} !== 13'b0) begin
         $display("FAIL reset_state: got %b want 0",
                  {busy, done, offset_idx, match_offset, match_len});
      end else begin
         n_pass++;
      end
      @(posedge clk); #1;
      n_checks++;
      if ({busy, done} !== 2'b00) begin
         $display("FAIL reset_start_ignored: busy/done got %b want 00",
                  {busy, done});
      end else begin
         n_pass++;
      end
   endtask

   task automatic test_tie();
      logic [2:0] v [9] = '{3'd1, 3'd3, 3'd0, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd2};
      for (int i = 0; i < 16; i++) len_tbl[i] = (i < 9) ? v[i] : 3'd7;
      run_search("tie", 9, 7, 1'b0);
      n_checks++;
      if ({match_offset, match_len} !== {4'd1, 3'd3}) begin
         $display("FAIL tie_const: off=%0d len=%0d want off=1 len=3",
                  match_offset, match_len);
      end else begin
         n_pass++;
      end
   endtask

   task automatic test_early_exit();
      for (int i = 0; i < 16; i++) len_tbl[i] = 3'd1;
      len_tbl[2] = 3'd5;
      run_search("early_exit", 9, 4, 1'b0);
      n_checks++;
      if ({match_offset, match_len} !== {4'd2, 3'd4}) begin
         $display("FAIL early_const: off=%0d len=%0d want off=2 len=4",
                  match_offset, match_len);
      end else begin
         n_pass++;
      end
   endtask

   task automatic test_empty();
      for (int i = 0; i < 16; i++) len_tbl[i] = 3'd6;
      run_search("empty_win", 0, 7, 1'b0);
      run_search("zero_len", 5, 7, 1'b0);
      for (int i = 0; i < 16; i++) len_tbl[i] = 3'd0;
      run_search("all_zero", 5, 7, 1'b0);
      for (int i = 0; i < 16; i++) len_tbl[i] = 3'd5;
      run_search("max_len0", 9, 0, 1'b0);
      for (int i = 0; i < 16; i++) len_tbl[i] = 3'd2;
      len_tbl[8] = 3'd3;
      run_search("saturate", 15, 7, 1'b0);
   endtask

   task automatic test_reset_mid_scan();
      bit quiet;
      for (int i = 0; i < 16; i++) len_tbl[i] = 3'd1;
      @(posedge clk); #1;
      start   = 1'b1;
      win_cnt = 4'd9;
      max_len = 3'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({busy, offset_idx} !== 5'b10011) begin
         $display("FAIL mid_scan_pos: busy/off got %b want 10011",
                  {busy, offset_idx});
      end else begin
         n_pass++;
      end
      reset   = 1'b1;
      start   = 1'b1;
      win_cnt = 4'd5;
      @(posedge clk); #1;
      reset = 1'b0;
      start = 1'b0;
      n_checks++;
      if ({busy, done, offset_idx, match_offset, match_len} !== 13'b0) begin
         $display("FAIL abort_state: got %b want 0",
                  {busy, done, offset_idx, match_offset, match_len});
      end else begin
         n_pass++;
      end
      quiet = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (busy !== 1'b0 || done !== 1'b0) quiet = 1'b0;
      end
      n_checks++;
      if (!quiet) begin
         $display("FAIL abort_no_done: activity seen=1 want 0");
      end else begin
         n_pass++;
      end
      for (int i = 0; i < 16; i++) len_tbl[i] = 3'($urandom_range(0, 6));
      run_search("post_reset", 9, 7, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) len_tbl[i] = 3'($urandom_range(0, 5));
      run_search("spam_full", 9, 6, 1'b1);
      for (int i = 0; i < 16; i++) len_tbl[i] = 3'($urandom_range(0, 7));
      run_search("spam_any", 7, 7, 1'b1);
   endtask

   task automatic test_random();
      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < 16; i++) len_tbl[i] = 3'($urandom_range(0, 7));
         run_search("random", int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 7)), 1'($urandom));
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) len_tbl[i] = 3'd0;
      test_reset();
      test_tie();
      test_early_exit();
      test_empty();
      test_reset_mid_scan();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lz77_match_sel.md
LZ77_MATCH_SEL -- requirements
Module: lz77_match_sel

Interface
REQ-001 The block SHALL have the parameter WIN, default 9, meaning the number of search-window offsets scanned (offsets 0..WIN-1).
REQ-002 The block SHALL have the port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have the port start, input, 1 bit: one-cycle request to begin a match search for the current encoder position.
REQ-005 The block SHALL have the port win_cnt, input, 4 bits: number of valid search-window entries (0..WIN), sampled on the start cycle.
REQ-006 The block SHALL have the port max_len, input, 3 bits: maximum legal match length (lookahead remaining minus 1), sampled on the start cycle.
REQ-007 The block SHALL have the port len_in, input, 3 bits: combinational match length from the comparator stage for the offset on offset_idx.
REQ-008 The block SHALL have the port offset_idx, output, 4 bits: offset currently presented to the upstream window mux and comparator.
REQ-009 The block SHALL have the port busy, output, 1 bit: search in progress.
REQ-010 The block SHALL have the port done, output, 1 bit: one-cycle pulse; result valid.
REQ-011 The block SHALL have the port match_offset, output, 4 bits: chosen offset, held until the next done.
REQ-012 The block SHALL have the port match_len, output, 3 bits: chosen length, held until the next done.

Function
REQ-013 The FSM SHALL have the states IDLE, SCAN and DONE.
REQ-014 In IDLE, start SHALL latch win_cnt and max_len, clear best_len/best_off to 0, and go to SCAN with offset_idx=0; if the latched win_cnt is 0, it SHALL go directly to DONE instead.
REQ-015 In SCAN, each cycle SHALL sample eff_len = min(len_in, max_len_latched) for the current offset_idx.
REQ-016 The best-match update SHALL be strict greater-than (eff_len > best_len), so the smallest offset wins ties and a zero-length result reports offset 0.
REQ-017 In SCAN, offset_idx SHALL increment by 1 per cycle.
REQ-018 SCAN SHALL exit to DONE after sampling offset win_cnt-1, or early in the same cycle that eff_len == max_len_latched (no longer match possible).
REQ-019 DONE SHALL last exactly one cycle, with done=1 and match_offset/match_len updated from best, then return to IDLE.
REQ-020 Latency: start at cycle t, with N offsets sampled, SHALL give done at cycle t+1+N; with win_cnt=0, done SHALL occur at t+1.
REQ-021 start SHALL be ignored while busy or done is high; there is no queuing.
REQ-022 busy SHALL be 1 exactly in SCAN.
REQ-023 offset_idx SHALL be 0 outside SCAN and SHALL never exceed WIN-1.
REQ-024 A max_len of 0 SHALL give match_len=0 and match_offset=0 after one SCAN cycle (early exit at offset 0).
REQ-025 A win_cnt greater than WIN SHALL be saturated to WIN.

Reset
REQ-026 On reset=1 at a clock edge, the FSM SHALL go to IDLE, and offset_idx, busy, done, match_offset, match_len and the internal best/latched registers SHALL all be 0.
REQ-027 Reset asserted mid-SCAN SHALL abort the search with no done pulse.
REQ-028 A start coincident with reset SHALL be ignored.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, WIN_DEFAULT=9 and the length width LEN_W=3, shared with the comparator stage and the encoder top.
REQ-030 The block SHALL be a single module with no sub-modules, instantiating nothing.
REQ-031 The comparator SHALL stay external, driven by offset_idx.

Verification
REQ-032 win_cnt=9, max_len=7, len_in per offset {1,3,0,3,2,1,0,0,2}: done at t+10 with match_offset=1, match_len=3 (tie resolved to the lower offset).
REQ-033 win_cnt=9, max_len=4, len_in=5 at offset 2 (others 1): early exit, done at t+4 with match_offset=2, match_len=4.
REQ-034 win_cnt=0 with start: done at t+1, match_len=0, match_offset=0, busy never high.
REQ-035 win_cnt=5, all len_in=0: done at t+6, match_offset=0, match_len=0, and offset_idx observed as 0..4 only.
REQ-036 reset pulsed at SCAN offset 3: no done, state IDLE, all outputs 0; a following start performs a clean full search.
REQ-037 start re-pulsed during SCAN and on the done cycle: ignored, with exactly one done per accepted start.
